// File: rtl/ser_10b_pkg.sv
// Shared definitions for the 10-bit serial transmit stage.
//   SYM_W        : encoded symbol width (fixed at 10)
//   K28_5_RDN/P  : K28.5 comma for RD- / RD+ (idle filler when SER_IDLE_COMMA_EN is defined)
//   FILL_NEUTRAL : balanced filler (5 ones) used when SER_IDLE_COMMA_EN is undefined
//   ones_cnt_t   : ones count of a symbol, 0..10
package ser_10b_pkg;

  localparam int unsigned SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN    = 10'h17C;
  localparam logic [SYM_W-1:0] K28_5_RDP    = 10'h283;
  localparam logic [SYM_W-1:0] FILL_NEUTRAL = 10'h155;

  typedef logic [3:0] ones_cnt_t;

endpackage

// File: rtl/ser_10b_tx_if.sv
// Symbol handshake between the 8b/10b encoder and the serializer.
//   data_in    : encoded symbol, bit[0]=a ... bit[9]=j
//   data_valid : data_in is valid
//   data_ready : serializer holding register is empty
// master = encoder side, slave = serializer side.
interface ser_10b_tx_if;
  import ser_10b_pkg::*;

  logic [SYM_W-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/popcnt_10b.sv
// Combinational ones counter for one 10-bit symbol.
//   sym_i  : symbol
//   ones_o : number of set bits, 0..10
module popcnt_10b
  import ser_10b_pkg::*;
(
  input  logic [9:0] sym_i,
  output ones_cnt_t  ones_o
);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < 10; i++) begin
      ones_o = ones_o + ones_cnt_t'(sym_i[i]);
    end
  end

endmodule

// File: rtl/ser_10b_tx.sv
// Parallel-to-serial transmit stage after the 8b/10b encoder.
// One symbol is accepted into a holding register over the bus handshake and shifted out one bit
// per clk. Every 10 cycles a new frame is loaded from the holding register, or from a filler
// symbol when it is empty (underrun). Running disparity of the sent stream is reported on rd_out.
// Build option: define SER_IDLE_COMMA_EN to use RD-matched K28.5 as filler instead of 10'h155.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : slave side of ser_10b_tx_if (data_in / data_valid / data_ready)
//   ser_out     : serial bit stream
//   frame_start : high while ser_out carries the first bit of a frame
//   underrun    : pulse with frame_start when the frame is filler
//   sym_err     : pulse with frame_start when the loaded symbol has not 4, 5 or 6 ones
//   rd_out      : running disparity after the current frame (0 = RD-, 1 = RD+)
module ser_10b_tx #(
  parameter int unsigned SYM_W     = ser_10b_pkg::SYM_W,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  ser_10b_tx_if.slave   bus,
  output logic          ser_out,
  output logic          frame_start,
  output logic          underrun,
  output logic          sym_err,
  output logic          rd_out
);
  import ser_10b_pkg::*;

  localparam logic [3:0] LastBit = 4'(SYM_W - 1);

  logic [SYM_W-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [SYM_W-1:0] shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             rd_q, rd_d;
  logic             data_ready_q, data_ready_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic             sym_err_q, sym_err_d;

  logic             load;
  logic             accept;
  logic [SYM_W-1:0] fill_sym;
  logic [SYM_W-1:0] load_sym;
  ones_cnt_t        load_ones;

  assign load   = (bit_cnt_q == LastBit);
  assign accept = bus.data_valid && data_ready_q;

`ifdef SER_IDLE_COMMA_EN
  // K28.5 of the current disparity; its own imbalance flips rd, so idle stays DC balanced.
  assign fill_sym = rd_q ? K28_5_RDP : K28_5_RDN;
`else
  assign fill_sym = FILL_NEUTRAL;
`endif

  assign load_sym = hold_valid_q ? hold_q : fill_sym;

  popcnt_10b u_popcnt (
    .sym_i  (load_sym),
    .ones_o (load_ones)
  );

  always_comb begin
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    rd_d          = rd_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    sym_err_d     = 1'b0;

    if (load) begin
      shreg_d       = load_sym;
      bit_cnt_d     = '0;
      hold_valid_d  = 1'b0;
      frame_start_d = 1'b1;
      underrun_d    = !hold_valid_q;
      case (load_ones)
        4'd6:    rd_d = 1'b1;
        4'd4:    rd_d = 1'b0;
        4'd5:    rd_d = rd_q;
        default: sym_err_d = 1'b1;
      endcase
    end else begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    end

    // Accept only happens while hold is empty, so it never collides with a drain.
    if (accept) begin
      hold_d       = bus.data_in;
      hold_valid_d = 1'b1;
    end

    data_ready_d = !hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      shreg_q       <= '0;
      bit_cnt_q     <= LastBit;
      rd_q          <= 1'b0;
      data_ready_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      sym_err_q     <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      rd_q          <= rd_d;
      data_ready_q  <= data_ready_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      sym_err_q     <= sym_err_d;
    end
  end

  // Output end of the shift register is itself a flop, so ser_out is registered.
  assign ser_out        = LSB_FIRST ? shreg_q[0] : shreg_q[SYM_W-1];
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign sym_err        = sym_err_q;
  assign rd_out         = rd_q;
  assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_ser_10b_tx.sv
// Self-checking bench for ser_10b_tx: one LSB-first and one MSB-first instance share the stimulus.
// The reference model works per frame: every 10th edge after reset release takes the waiting symbol
// (or the filler), rd follows the ones count of that symbol, and ser_out is the frame symbol read
// out bit by bit.
module tb_ser_10b_tx;

`ifdef SER_IDLE_COMMA_EN
  localparam bit CommaFill = 1'b1;
`else
  localparam bit CommaFill = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ser_10b_tx_if u_if_lsb ();
  ser_10b_tx_if u_if_msb ();

  assign u_if_msb.data_in    = u_if_lsb.data_in;
  assign u_if_msb.data_valid = u_if_lsb.data_valid;

  logic ser_lsb, fs_lsb, ur_lsb, se_lsb, rd_lsb;
  logic ser_msb, fs_msb, ur_msb, se_msb, rd_msb;

  ser_10b_tx #(.SYM_W(10), .LSB_FIRST(1'b1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_if_lsb),
    .ser_out     (ser_lsb),
    .frame_start (fs_lsb),
    .underrun    (ur_lsb),
    .sym_err     (se_lsb),
    .rd_out      (rd_lsb)
  );

  ser_10b_tx #(.SYM_W(10), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (u_if_msb),
    .ser_out     (ser_msb),
    .frame_start (fs_msb),
    .underrun    (ur_msb),
    .sym_err     (se_msb),
    .rd_out      (rd_msb)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  string stage = "init";

  // Reference model state.
  int         m_e = 0;          // edges since reset release
  bit         m_hold_full = 1'b0;
  logic [9:0] m_hold = '0;
  bit         m_rd = 1'b0;
  logic [9:0] m_sym = '0;       // symbol of the frame in flight
  bit         m_fill = 1'b0;
  bit         m_bad = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h expected %0h", stage, tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] fill_for(input bit rd);
    if (CommaFill) return rd ? 10'h283 : 10'h17C;
    return 10'h155;
  endfunction

  function automatic logic [9:0] rand_legal();
    logic [9:0] s;
    for (int k = 0; k < 100; k++) begin
      s = 10'($urandom);
      if ($countones(s) >= 4 && $countones(s) <= 6) return s;
    end
    return 10'h155;
  endfunction

  // Model update for one rising edge, using the inputs as driven before that edge.
  function automatic void model_edge();
    bit accept;
    int ones;
    if (!rst_n) begin
      m_e = 0; m_hold_full = 1'b0; m_rd = 1'b0; m_sym = '0; m_fill = 1'b0; m_bad = 1'b0;
      return;
    end
    accept = u_if_lsb.data_valid && (m_e > 0) && !m_hold_full;
    m_e++;
    if ((m_e - 1) % 10 == 0) begin
      if (m_hold_full) begin
        m_sym = m_hold; m_fill = 1'b0; m_hold_full = 1'b0;
      end else begin
        m_sym = fill_for(m_rd); m_fill = 1'b1;
      end
      ones  = $countones(m_sym);
      m_bad = (ones < 4) || (ones > 6);
      if (ones == 6) m_rd = 1'b1;
      else if (ones == 4) m_rd = 1'b0;
    end
    if (accept) begin
      m_hold_full = 1'b1;
      m_hold      = u_if_lsb.data_in;
    end
  endfunction

  task automatic check_outputs();
    int pos;
    if (m_e == 0) begin
      chk("rst_ser_out", ser_lsb, 0);
      chk("rst_ser_out_msb", ser_msb, 0);
      chk("rst_frame_start", fs_lsb, 0);
      chk("rst_underrun", ur_lsb, 0);
      chk("rst_sym_err", se_lsb, 0);
      chk("rst_rd_out", rd_lsb, 0);
      chk("rst_data_ready", u_if_lsb.data_ready, 0);
      chk("rst_data_ready_msb", u_if_msb.data_ready, 0);
    end else begin
      pos = (m_e - 1) % 10;
      chk("ser_out", ser_lsb, m_sym[pos]);
      chk("ser_out_msb", ser_msb, m_sym[9-pos]);
      chk("frame_start", fs_lsb, 32'(pos == 0));
      chk("frame_start_msb", fs_msb, 32'(pos == 0));
      chk("underrun", ur_lsb, 32'(pos == 0 && m_fill));
      chk("sym_err", se_lsb, 32'(pos == 0 && m_bad));
      chk("rd_out", rd_lsb, 32'(m_rd));
      chk("rd_out_msb", rd_msb, 32'(m_rd));
      chk("data_ready", u_if_lsb.data_ready, 32'(!m_hold_full));
      chk("data_ready_msb", u_if_msb.data_ready, 32'(!m_hold_full));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Present d with valid until the DUT shows ready at a sampling edge; bounded wait.
  task automatic push(input logic [9:0] d);
    logic seen;
    seen = 1'b0;
    u_if_lsb.data_valid = 1'b1;
    u_if_lsb.data_in    = d;
    for (int k = 0; k < 12; k++) begin
      seen = u_if_lsb.data_ready;
      tick();
      if (seen) break;
    end
    u_if_lsb.data_valid = 1'b0;
    chk("push_accepted", 32'(seen), 1);
  endtask

  initial begin
    u_if_lsb.data_valid = 1'b0;
    u_if_lsb.data_in    = '0;
    rst_n               = 1'b0;

    // Handshake activity under reset is ignored.
    stage = "reset";
    repeat (3) begin
      u_if_lsb.data_valid = 1'($urandom_range(0, 1));
      u_if_lsb.data_in    = 10'($urandom);
      tick();
    end
    u_if_lsb.data_valid = 1'b0;
    rst_n = 1'b1;

    stage = "idle";
    repeat (30) tick();

    stage = "push_2b5";
    repeat ($urandom_range(0, 9)) tick();
    push(10'h2B5);
    repeat (20) tick();

    stage = "back_to_back";
    for (int i = 0; i < 3; i++) push(rand_legal());
    repeat (30) tick();

    stage = "illegal";
    push(10'h3FF);
    repeat (20) tick();

    stage = "msb_first";
    push(10'h001);
    repeat (20) tick();

    stage = "random";
    repeat (300) begin
      u_if_lsb.data_valid = 1'($urandom_range(0, 1));
      u_if_lsb.data_in    = ($urandom_range(0, 1) == 1) ? rand_legal() : 10'($urandom);
      tick();
    end
    u_if_lsb.data_valid = 1'b0;
    repeat (25) tick();

    // Fill hold right after a load, then reset while bit 4 is on the line.
    stage = "mid_reset";
    for (int k = 0; k < 20; k++) begin
      if ((m_e - 1) % 10 == 0) break;
      tick();
    end
    u_if_lsb.data_valid = 1'b1;
    u_if_lsb.data_in    = rand_legal();
    tick();
    u_if_lsb.data_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((m_e - 1) % 10 == 4) break;
      tick();
    end
    chk("hold_full_before_reset", u_if_lsb.data_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
